// File: rtl/watch_cu.sv
// Watch control unit: turns debounced button levels into one-cycle tick pulses
// for watch_dp, with RUN/SET mode, field select, press-and-hold auto-repeat and lock.
module watch_cu #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_sel,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic       o_tick_sec_up,
  output logic       o_tick_sec_down,
  output logic       o_tick_min_up,
  output logic       o_tick_min_down,
  output logic       o_tick_hour_up,
  output logic       o_tick_hour_down,
  output logic       o_set_mode,
  output logic [1:0] o_field
);

  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {MODE_RUN = 1'b0, MODE_SET = 1'b1} mode_e;
  typedef enum logic [1:0] {FLD_SEC = 2'd0, FLD_MIN = 2'd1, FLD_HOUR = 2'd2} field_e;

  // Button bit order in the sample registers: 0 mode, 1 sel, 2 up, 3 down.
  logic [3:0]    smp_q, prv_q;
  mode_e         mode_q, mode_d;
  field_e        field_q, field_d;
  logic          lock_q, lock_d;
  logic          rep_q, rep_d;
  logic [CW-1:0] cnt_q, cnt_d, limit;
  logic [5:0]    tick_q, tick_d;

  logic mode_edge, sel_edge, up_eff, dn_eff, up_rise, dn_rise, any_eff, gen, pulse;

  always_comb begin
    mode_edge = smp_q[0] & ~prv_q[0];
    sel_edge  = smp_q[1] & ~prv_q[1];
    up_eff    = smp_q[2] & ~smp_q[3];
    dn_eff    = smp_q[3] & ~smp_q[2];
    up_rise   = up_eff & ~(prv_q[2] & ~prv_q[3]);
    dn_rise   = dn_eff & ~(prv_q[3] & ~prv_q[2]);
    any_eff   = up_eff | dn_eff;

    mode_d  = mode_q;
    field_d = field_q;
    if (mode_edge) begin
      if (mode_q == MODE_RUN) begin
        mode_d  = MODE_SET;
        field_d = FLD_SEC;
      end else begin
        mode_d  = MODE_RUN;
      end
    end else if (sel_edge && (mode_q == MODE_SET)) begin
      case (field_q)
        FLD_SEC: field_d = FLD_MIN;
        FLD_MIN: field_d = FLD_HOUR;
        default: field_d = FLD_SEC;
      endcase
    end

    lock_d = lock_q;
    if ((mode_edge | sel_edge) & any_eff) lock_d = 1'b1;
    else if (!any_eff)                    lock_d = 1'b0;

    // Judging against next-state mode/lock means a press coinciding with entry
    // into SET, or with a lock-setting edge, never slips a pulse through.
    gen   = (mode_d == MODE_SET) & ~lock_d & any_eff;
    limit = rep_q ? CW'(REPEAT_CYCLES - 1) : CW'(HOLD_CYCLES - 1);
    pulse = 1'b0;
    cnt_d = '0;
    rep_d = 1'b0;
    if (gen) begin
      if (up_rise | dn_rise) begin
        pulse = 1'b1;
      end else if (cnt_q == limit) begin
        pulse = 1'b1;
        rep_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        rep_d = rep_q;
      end
    end

    tick_d = '0;
    if (pulse) tick_d = 6'b000001 << {field_d, dn_eff};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q   <= '0;
      prv_q   <= '0;
      mode_q  <= MODE_RUN;
      field_q <= FLD_SEC;
      lock_q  <= 1'b0;
      rep_q   <= 1'b0;
      cnt_q   <= '0;
      tick_q  <= '0;
    end else begin
      smp_q   <= {i_btn_down, i_btn_up, i_btn_sel, i_btn_mode};
      prv_q   <= smp_q;
      mode_q  <= mode_d;
      field_q <= field_d;
      lock_q  <= lock_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  assign o_tick_sec_up    = tick_q[0];
  assign o_tick_sec_down  = tick_q[1];
  assign o_tick_min_up    = tick_q[2];
  assign o_tick_min_down  = tick_q[3];
  assign o_tick_hour_up   = tick_q[4];
  assign o_tick_hour_down = tick_q[5];
  assign o_set_mode       = (mode_q == MODE_SET);
  assign o_field          = field_q;

endmodule

// File: tb/tb_watch_cu.sv
// Directed bench for watch_cu: tick events are logged as {cycle, tick vector}
// and matched against hand-computed expected events.
module tb_watch_cu;

  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int B_MODE = 0, B_SEL = 1, B_UP = 2, B_DN = 3;
  localparam int T_SEC_UP = 0, T_SEC_DN = 1, T_MIN_UP = 2, T_MIN_DN = 3, T_HOUR_UP = 4, T_HOUR_DN = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_sel = 1'b0, btn_up = 1'b0, btn_dn = 1'b0;
  logic       sec_up, sec_dn, min_up, min_dn, hour_up, hour_dn;
  logic       set_mode;
  logic [1:0] field;
  logic [5:0] ticks;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  watch_cu #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst),
    .i_btn_mode(btn_mode), .i_btn_sel(btn_sel), .i_btn_up(btn_up), .i_btn_down(btn_dn),
    .o_tick_sec_up(sec_up), .o_tick_sec_down(sec_dn),
    .o_tick_min_up(min_up), .o_tick_min_down(min_dn),
    .o_tick_hour_up(hour_up), .o_tick_hour_down(hour_dn),
    .o_set_mode(set_mode), .o_field(field)
  );

  assign ticks = {hour_dn, hour_up, min_dn, min_up, sec_dn, sec_up};

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event monitor: every nonzero tick cycle is logged with the edge index.
  always @(negedge clk) begin
    if (ticks != 6'b0) begin
      got_q.push_back({cyc[25:0], ticks});
      check("onehot", 32'($countones(ticks)), 32'd1);
    end
  end

  // Driver tasks
  task automatic set_btn(input int b, input logic v);
    case (b)
      B_MODE:  btn_mode = v;
      B_SEL:   btn_sel  = v;
      B_UP:    btn_up   = v;
      default: btn_dn   = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // p = index of the clock edge that first samples the press.
  task automatic press(input int b, input int n, output int p);
    @(negedge clk);
    set_btn(b, 1'b1);
    p = cyc + 1;
    repeat (n) @(negedge clk);
    set_btn(b, 1'b0);
  endtask

  task automatic exp_ev(input int c, input int t);
    logic [5:0] v;
    v = 6'b000001 << t;
    exp_q.push_back({c[25:0], v});
  endtask

  // Scoreboard
  task automatic match_events(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check(tag, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    int p, q;
    idle(3);
    check("rst_mode", 32'(set_mode), 32'd0);
    check("rst_field", 32'(field), 32'd0);
    check("rst_ticks", 32'(ticks), 32'd0);
    rst = 1'b0;

    // 1: up held in RUN produces nothing
    press(B_UP, 100, p);
    idle(5);
    match_events("t1");
    check("t1_mode", 32'(set_mode), 32'd0);
    check("t1_field", 32'(field), 32'd0);

    // 2: enter SET, short up press -> one sec_up one cycle after the edge
    press(B_MODE, 2, p);
    idle(2);
    check("t2_mode", 32'(set_mode), 32'd1);
    check("t2_field", 32'(field), 32'd0);
    press(B_UP, 3, p);
    exp_ev(p + 1, T_SEC_UP);
    idle(5);
    match_events("t2");

    // 3: select hour, hold down 40 cycles -> press pulse plus auto-repeat
    press(B_SEL, 2, p);
    idle(2);
    check("t3_field1", 32'(field), 32'd1);
    press(B_SEL, 2, p);
    idle(2);
    check("t3_field2", 32'(field), 32'd2);
    press(B_DN, 40, p);
    exp_ev(p + 1, T_HOUR_DN);
    exp_ev(p + 1 + HOLD, T_HOUR_DN);
    exp_ev(p + 1 + HOLD + REP, T_HOUR_DN);
    exp_ev(p + 1 + HOLD + 2 * REP, T_HOUR_DN);
    exp_ev(p + 1 + HOLD + 3 * REP, T_HOUR_DN);
    idle(30);
    match_events("t3");

    // 4: wrap to sec; up+down together silent, releasing down is a fresh up press
    press(B_SEL, 2, p);
    idle(2);
    check("t4_field", 32'(field), 32'd0);
    @(negedge clk);
    btn_up = 1'b1;
    btn_dn = 1'b1;
    idle(30);
    btn_dn = 1'b0;
    p = cyc + 1;
    exp_ev(p + 1, T_SEC_UP);
    idle(3);
    btn_up = 1'b0;
    idle(5);
    match_events("t4");

    // 5: sel mid-hold locks out repeats until release; re-press works on min
    @(negedge clk);
    btn_up = 1'b1;
    p = cyc + 1;
    exp_ev(p + 1, T_SEC_UP);
    idle(8);
    press(B_SEL, 2, q);
    idle(40);
    btn_up = 1'b0;
    idle(3);
    check("t5_field", 32'(field), 32'd1);
    press(B_UP, 3, p);
    exp_ev(p + 1, T_MIN_UP);
    idle(5);
    match_events("t5");

    // 6: reset mid-repeat, then entering SET with up still held stays locked
    @(negedge clk);
    btn_up = 1'b1;
    p = cyc + 1;
    exp_ev(p + 1, T_MIN_UP);
    exp_ev(p + 1 + HOLD, T_MIN_UP);
    idle(23);
    rst = 1'b1;
    idle(1);
    check("t6_rst_mode", 32'(set_mode), 32'd0);
    check("t6_rst_field", 32'(field), 32'd0);
    check("t6_rst_ticks", 32'(ticks), 32'd0);
    rst = 1'b0;
    idle(5);
    press(B_MODE, 2, q);
    idle(30);
    check("t6_mode", 32'(set_mode), 32'd1);
    check("t6_field", 32'(field), 32'd0);
    btn_up = 1'b0;
    idle(3);
    press(B_DN, 3, q);
    exp_ev(q + 1, T_SEC_DN);
    idle(5);
    match_events("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/watch_cu.md
Name: watch_cu

Overview:
- Control unit that sits in front of watch_dp. It turns debounced push-button levels into the one-cycle tick_*_up / tick_*_down pulses that watch_dp consumes.
- It owns the RUN/SET mode state machine and the field-select state machine.
- It applies press-and-hold auto-repeat to the up/down buttons.
- It exports the mode and the selected field for the display path.

Parameters:
- HOLD_CYCLES, 50_000_000, cycles a button must be held after its press pulse before the first auto-repeat pulse (0.5 s at 100 MHz).
- REPEAT_CYCLES, 10_000_000, cycles between successive auto-repeat pulses (0.1 s at 100 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- i_btn_mode  input  1  debounced level; rising edge toggles RUN/SET
- i_btn_sel  input  1  debounced level; rising edge advances the set field
- i_btn_up  input  1  debounced level; increment request
- i_btn_down  input  1  debounced level; decrement request
- o_tick_sec_up, o_tick_sec_down  output  1 each  one-cycle pulses to watch_dp
- o_tick_min_up, o_tick_min_down  output  1 each  one-cycle pulses to watch_dp
- o_tick_hour_up, o_tick_hour_down  output  1 each  one-cycle pulses to watch_dp
- o_set_mode  output  1  1 = SET mode, 0 = RUN mode
- o_field  output  2  selected field: 0 = sec, 1 = min, 2 = hour; value 3 never driven

Behaviour:

Clocking and reset
- Single clock domain. All state and outputs are registered.
- Reset is synchronous and active-high, and takes priority over all other activity.
- On reset: mode = RUN, o_set_mode = 0, o_field = 0, all six tick outputs = 0, hold/repeat counter = 0, lock = 0.
- On reset, all previous-sample registers load 0. A button already held through reset release therefore produces an edge on the first sampled cycle after reset.

Edge detection
- Each input is compared with its previous sample.
- An edge on cycle N (input 1 at edge N, 0 at edge N-1) produces its effect registered at edge N+1. Pulse latency is 1 cycle.

Mode FSM (RUN, SET)
- A mode edge toggles the mode.
- RUN -> SET sets field = sec.
- SET -> RUN keeps o_field unchanged; o_field is ignored downstream in RUN.

Field FSM (SET mode only)
- A sel edge advances the field sec -> min -> hour -> sec.
- Sel edges in RUN are ignored.
- If mode and sel edges occur on the same cycle, mode wins and sel is ignored.

Up/down gating
- up_eff = i_btn_up & ~i_btn_down; dn_eff = i_btn_down & ~i_btn_up.
- Both buttons high: no pulses, counter held at 0.
- Releasing one of the two makes the remaining button's *_eff rise. That counts as a fresh press.

Pulse generation
- Pulses are generated only in SET mode, with lock = 0.
- A rising edge of up_eff (dn_eff) pulses the up (down) tick of the selected field once.

Auto-repeat
- While *_eff stays high, the counter counts from 0 after the press pulse.
- At count HOLD_CYCLES-1: emit one pulse and reset the counter. Subsequent pulses then come every REPEAT_CYCLES cycles (at count REPEAT_CYCLES-1).
- Dropping *_eff clears the counter and the repeat phase.
- Pulse spacing: first repeat exactly HOLD_CYCLES cycles after the press pulse; then REPEAT_CYCLES cycles apart.

Lock
- A mode or sel edge while up_eff or dn_eff is high sets lock = 1 and clears the counter.
- While lock = 1, no tick pulses are generated.
- Lock clears when both up_eff and dn_eff are 0. The next press then behaves normally.

Output constraints
- At most one of the six tick outputs is high in any cycle.
- Every tick output is high for exactly 1 cycle per event.

RUN mode
- Up/down buttons produce no pulses and the counter stays at 0.
- Entering SET while up is held produces no pulse, because the lock rule applies.

Width rules
- Counter width is $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
- Counter compares are exact equality. No overflow is possible.

Test Plan:
(Run with HOLD_CYCLES=20, REPEAT_CYCLES=5.)
1. Reset, then an up press in RUN held for 100 cycles -> no tick outputs ever high; o_set_mode=0, o_field=0.
2. Mode edge -> o_set_mode=1, o_field=0. Then an up press (3 cycles) -> o_tick_sec_up high for exactly one cycle, 1 cycle after the edge; nothing else.
3. SET, two sel edges -> o_field=2. Then a down press held 40 cycles -> o_tick_hour_down pulses at press+1, +21, +26, +31, +36; none after release.
4. SET, sel edges from field 2 -> field wraps to 0. Then simultaneous up+down held 30 cycles -> no pulses. Releasing down while up is held -> o_tick_sec_up pulse 1 cycle later.
5. SET, hold up, issue a sel edge mid-hold -> no further pulses until up is released. Re-press -> o_tick_min_up single pulse.
6. Hold up in SET, assert rst for 1 cycle mid-repeat -> next cycle shows RUN, o_field=0, counters 0, all ticks 0. After a mode edge with up still held -> no pulse (lock).
